// File: rtl/sb_pkg.sv
// Shared types for the multi-port scoreboard: issue payload, exception record and commit slot.
package sb_pkg;

    localparam int unsigned REG_ADDR_SIZE = 5;
    localparam int unsigned SB_XLEN       = 64;
    localparam int unsigned CAUSE_W       = 6;
    localparam int unsigned OP_W          = 8;

    typedef enum logic [3:0] {
        FU_NONE,
        FU_ALU,
        FU_BRANCH,
        FU_LOAD,
        FU_STORE,
        FU_MULT,
        FU_CSR,
        FU_FPU
    } fu_t;

    typedef struct packed {
        logic [REG_ADDR_SIZE-1:0] rd;
        logic                     rd_is_fpr;
        fu_t                      fu;
        logic [OP_W-1:0]          op;
        logic [SB_XLEN-1:0]       pc;
    } sb_entry_t;

    typedef struct packed {
        logic               valid;
        logic [CAUSE_W-1:0] cause;
        logic [SB_XLEN-1:0] tval;
    } sb_ex_t;

    typedef struct packed {
        sb_entry_t          entry;
        logic [SB_XLEN-1:0] result;
        sb_ex_t             ex;
    } sb_commit_t;

endpackage

// File: rtl/sb_age_select.sv
// Picks the youngest matching entry (largest distance from the commit pointer) as a one-hot vector.
module sb_age_select
    import sb_pkg::*;
#(
    parameter  int unsigned NR_ENTRIES = 8,
    localparam int unsigned IDW        = $clog2(NR_ENTRIES)
) (
    input  logic [NR_ENTRIES-1:0] match,
    input  logic [IDW-1:0]        commit_ptr,
    output logic [NR_ENTRIES-1:0] sel,
    output logic                  hit
);

    logic [IDW-1:0] age;
    logic [IDW-1:0] best;

    always_comb begin
        sel  = '0;
        hit  = 1'b0;
        best = '0;
        age  = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            age = IDW'(e) - commit_ptr;
            if (match[e] && (!hit || age > best)) begin
                hit    = 1'b1;
                best   = age;
                sel    = '0;
                sel[e] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scoreboard_mp.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard with operand lookup.
// Optional SB_WB_FWD_EN: same-cycle bypass of writeback data into operand lookups.
module scoreboard_mp
    import sb_pkg::*;
#(
    parameter  int unsigned NR_ENTRIES      = 8,
    parameter  int unsigned NR_WB_PORTS     = 4,
    parameter  int unsigned NR_COMMIT_PORTS = 2,
    parameter  int unsigned NR_RD_PORTS     = 3,
    parameter  int unsigned XLEN            = 64,
    localparam int unsigned IDW             = $clog2(NR_ENTRIES)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic                                        issue_valid_i,
    output logic                                        issue_ready_o,
    input  sb_entry_t                                   issue_entry_i,
    output logic [IDW-1:0]                              issue_tid_o,
    input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDW-1:0]             wb_tid_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_data_i,
    input  sb_ex_t [NR_WB_PORTS-1:0]                    wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]                  commit_valid_o,
    output sb_commit_t [NR_COMMIT_PORTS-1:0]            commit_entry_o,
    input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i,
    input  logic [NR_RD_PORTS-1:0][REG_ADDR_SIZE-1:0]   rd_addr_i,
    input  logic [NR_RD_PORTS-1:0]                      rd_fpr_i,
    output logic [NR_RD_PORTS-1:0]                      rd_hit_o,
    output logic [NR_RD_PORTS-1:0]                      rd_valid_o,
    output logic [NR_RD_PORTS-1:0][XLEN-1:0]            rd_data_o,
    output logic [31:0]                                 gpr_busy_o,
    output logic [31:0]                                 fpr_busy_o,
    output logic [IDW:0]                                occupancy_o
);

    localparam int unsigned CNTW = IDW + 1;

    logic [NR_ENTRIES-1:0]     issued_q;
    logic [NR_ENTRIES-1:0]     done_q;
    sb_entry_t                 entry_q  [NR_ENTRIES];
    logic [SB_XLEN-1:0]        result_q [NR_ENTRIES];
    sb_ex_t                    ex_q     [NR_ENTRIES];
    logic [IDW-1:0]            issue_ptr_q;
    logic [IDW-1:0]            commit_ptr_q;
    logic [CNTW-1:0]           occ_q;

    logic                       accept;
    logic [NR_WB_PORTS-1:0]     wb_apply;
    logic [NR_COMMIT_PORTS-1:0] commit_clr;
    logic [CNTW-1:0]            n_commit;
    logic [IDW-1:0]             cidx;
    logic                       chain;
    logic                       run;

    assign issue_ready_o = (occ_q < CNTW'(NR_ENTRIES));
    assign issue_tid_o   = issue_ptr_q;
    assign occupancy_o   = occ_q;
    assign accept        = issue_valid_i && issue_ready_o;

    // Writeback lands only on an issued, not-yet-done entry that is not being allocated right now.
    always_comb begin
        wb_apply = '0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            wb_apply[p] = wb_valid_i[p] && issued_q[wb_tid_i[p]] && !done_q[wb_tid_i[p]]
                          && !(accept && (wb_tid_i[p] == issue_ptr_q));
        end
    end

    // Commit window: slot i is valid only while every older slot is valid too.
    always_comb begin
        commit_valid_o = '0;
        commit_entry_o = '0;
        commit_clr     = '0;
        n_commit       = '0;
        cidx           = '0;
        chain          = 1'b1;
        run            = 1'b1;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cidx              = commit_ptr_q + IDW'(i);
            chain             = chain & issued_q[cidx] & done_q[cidx];
            commit_valid_o[i] = chain;
            if (chain) begin
                commit_entry_o[i] = '{entry: entry_q[cidx], result: result_q[cidx], ex: ex_q[cidx]};
            end
            run           = run & commit_ack_i[i] & chain;
            commit_clr[i] = run;
            if (run) begin
                n_commit = n_commit + CNTW'(1);
            end
        end
    end

    // Control state; flush shares the reset path and overrides all same-cycle activity.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            issued_q     <= '0;
            done_q       <= '0;
            issue_ptr_q  <= '0;
            commit_ptr_q <= '0;
            occ_q        <= '0;
        end else begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_apply[p]) begin
                    done_q[wb_tid_i[p]] <= 1'b1;
                end
            end
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (commit_clr[i]) begin
                    issued_q[commit_ptr_q + IDW'(i)] <= 1'b0;
                    done_q[commit_ptr_q + IDW'(i)]   <= 1'b0;
                end
            end
            if (accept) begin
                issued_q[issue_ptr_q] <= 1'b1;
                done_q[issue_ptr_q]   <= 1'b0;
            end
            issue_ptr_q  <= issue_ptr_q + IDW'(accept);
            commit_ptr_q <= commit_ptr_q + IDW'(n_commit);
            occ_q        <= occ_q + CNTW'(accept) - n_commit;
        end
    end

    // Payload storage; later ports overwrite earlier ones on a (disallowed) tid collision.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            if (wb_apply[p]) begin
                result_q[wb_tid_i[p]] <= SB_XLEN'(wb_data_i[p]);
                if (wb_ex_i[p].valid) begin
                    ex_q[wb_tid_i[p]] <= wb_ex_i[p];
                end
            end
        end
        if (accept) begin
            entry_q[issue_ptr_q]    <= issue_entry_i;
            ex_q[issue_ptr_q].valid <= 1'b0;
        end
    end

    for (genvar r = 0; r < NR_RD_PORTS; r++) begin : g_rd
        logic [NR_ENTRIES-1:0] match;
        logic [NR_ENTRIES-1:0] sel;
        logic                  hit;
        logic                  sel_done;
        logic                  sel_exv;
        logic [SB_XLEN-1:0]    sel_res;
        logic                  valid;
        logic [XLEN-1:0]       data;

        always_comb begin
            match = '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                match[e] = issued_q[e] && (entry_q[e].rd == rd_addr_i[r])
                           && (entry_q[e].rd_is_fpr == rd_fpr_i[r])
                           && (rd_fpr_i[r] || (rd_addr_i[r] != '0));
            end
        end

        sb_age_select #(
            .NR_ENTRIES (NR_ENTRIES)
        ) u_age (
            .match      (match),
            .commit_ptr (commit_ptr_q),
            .sel        (sel),
            .hit        (hit)
        );

        always_comb begin
            sel_done = 1'b0;
            sel_exv  = 1'b0;
            sel_res  = '0;
            for (int e = 0; e < NR_ENTRIES; e++) begin
                if (sel[e]) begin
                    sel_done = done_q[e];
                    sel_exv  = ex_q[e].valid;
                    sel_res  = result_q[e];
                end
            end
            valid = hit && sel_done && !sel_exv;
            data  = valid ? XLEN'(sel_res) : '0;
`ifdef SB_WB_FWD_EN
            // Descending scan so the lowest port index has the final say.
            for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
                if (hit && wb_valid_i[p] && !wb_ex_i[p].valid && sel[wb_tid_i[p]]) begin
                    valid = 1'b1;
                    data  = wb_data_i[p];
                end
            end
`endif
        end

        assign rd_hit_o[r]   = hit;
        assign rd_valid_o[r] = valid;
        assign rd_data_o[r]  = data;
    end

    always_comb begin
        gpr_busy_o = '0;
        fpr_busy_o = '0;
        for (int e = 0; e < NR_ENTRIES; e++) begin
            if (issued_q[e]) begin
                if (entry_q[e].rd_is_fpr) begin
                    fpr_busy_o[entry_q[e].rd] = 1'b1;
                end else begin
                    gpr_busy_o[entry_q[e].rd] = 1'b1;
                end
            end
        end
        gpr_busy_o[0] = 1'b0;
    end

    logic wb_dup;
    logic ack_bad;

    always_comb begin
        wb_dup  = 1'b0;
        ack_bad = 1'b0;
        for (int p = 0; p < NR_WB_PORTS; p++) begin
            for (int q = p + 1; q < NR_WB_PORTS; q++) begin
                if (wb_valid_i[p] && wb_valid_i[q] && (wb_tid_i[p] == wb_tid_i[q])) begin
                    wb_dup = 1'b1;
                end
            end
        end
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (commit_ack_i[i] && !commit_clr[i]) begin
                ack_bad = 1'b1;
            end
        end
    end

    a_wb_unique_tid: assert property (@(posedge clk_i) disable iff (rst_i) !wb_dup);
    a_ack_prefix:    assert property (@(posedge clk_i) disable iff (rst_i || flush_i) !ack_bad);

endmodule

// File: tb/tb_scoreboard_mp.sv
// Directed self-checking bench for scoreboard_mp: issue/wrap, OoO writeback, commit, lookup, flush, reset.
module tb_scoreboard_mp;
    import sb_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned WBP = 4;
    localparam int unsigned CP  = 2;
    localparam int unsigned RDP = 3;
    localparam int unsigned XL  = 64;
    localparam int unsigned IDW = 3;
`ifdef SB_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          flush;
    logic                          issue_valid;
    logic                          issue_ready;
    sb_entry_t                     issue_entry;
    logic [IDW-1:0]                issue_tid;
    logic [WBP-1:0]                wb_valid;
    logic [WBP-1:0][IDW-1:0]       wb_tid;
    logic [WBP-1:0][XL-1:0]        wb_data;
    sb_ex_t [WBP-1:0]              wb_ex;
    logic [CP-1:0]                 commit_valid;
    sb_commit_t [CP-1:0]           commit_entry;
    logic [CP-1:0]                 commit_ack;
    logic [RDP-1:0][4:0]           rd_addr;
    logic [RDP-1:0]                rd_fpr;
    logic [RDP-1:0]                rd_hit;
    logic [RDP-1:0]                rd_valid;
    logic [RDP-1:0][XL-1:0]        rd_data;
    logic [31:0]                   gpr_busy;
    logic [31:0]                   fpr_busy;
    logic [IDW:0]                  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] rd_tab [8];

    always #5 clk = ~clk;

    scoreboard_mp #(
        .NR_ENTRIES      (N),
        .NR_WB_PORTS     (WBP),
        .NR_COMMIT_PORTS (CP),
        .NR_RD_PORTS     (RDP),
        .XLEN            (XL)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready),
        .issue_entry_i  (issue_entry),
        .issue_tid_o    (issue_tid),
        .wb_valid_i     (wb_valid),
        .wb_tid_i       (wb_tid),
        .wb_data_i      (wb_data),
        .wb_ex_i        (wb_ex),
        .commit_valid_o (commit_valid),
        .commit_entry_o (commit_entry),
        .commit_ack_i   (commit_ack),
        .rd_addr_i      (rd_addr),
        .rd_fpr_i       (rd_fpr),
        .rd_hit_o       (rd_hit),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .gpr_busy_o     (gpr_busy),
        .fpr_busy_o     (fpr_busy),
        .occupancy_o    (occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic sb_entry_t mk(input logic [4:0] rd, input logic fpr, input logic [63:0] pc);
        sb_entry_t e;
        e           = '0;
        e.rd        = rd;
        e.rd_is_fpr = fpr;
        e.fu        = FU_ALU;
        e.pc        = pc;
        return e;
    endfunction

    task automatic wb(input int port, input logic [IDW-1:0] tid, input logic [63:0] data, input logic exv);
        wb_valid[port]       = 1'b1;
        wb_tid[port]         = tid;
        wb_data[port]        = data;
        wb_ex[port]          = '0;
        wb_ex[port].valid    = exv;
        wb_ex[port].cause    = 6'd5;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        wb_valid    = '0;
        commit_ack  = '0;
        flush       = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        idle();
        issue_entry = '0;
        wb_tid      = '0;
        wb_data     = '0;
        wb_ex       = '0;
        rd_addr     = '0;
        rd_fpr      = '0;
        rd_tab      = '{5'd10, 5'd5, 5'd12, 5'd5, 5'd14, 5'd15, 5'd5, 5'd0};
        step();
        step();
        rst = 1'b0;

        check("rst_ready", issue_ready, 1);
        check("rst_occ", occupancy, 0);
        check("rst_tid", issue_tid, 0);
        check("rst_cvalid", commit_valid, 0);
        check("rst_cresult", commit_entry[0].result, 0);
        check("rst_gbusy", gpr_busy, 0);
        check("rst_fbusy", fpr_busy, 0);
        check("rst_rdvalid", rd_valid, 0);

        // Fill all eight slots; tid1 targets an FPR, tid7 targets x0
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1;
            issue_entry = mk(rd_tab[i], (i == 1), 64'h1000 + 64'(4 * i));
            check("issue_tid", issue_tid, 64'(i));
            check("issue_ready", issue_ready, 1);
            step();
        end
        check("full_ready", issue_ready, 0);
        check("full_occ", occupancy, 8);
        check("full_tid", issue_tid, 0);
        step();
        check("stall_occ", occupancy, 8);
        check("stall_tid", issue_tid, 0);
        issue_valid = 1'b0;
        check("gpr_busy", gpr_busy, 64'h0000_D420);
        check("fpr_busy", fpr_busy, 64'h0000_0020);

        // Out-of-order writeback holds commit until the head is done
        wb(1, 3'd1, 64'h11, 1'b0);
        step();
        idle();
        check("cv_wait_head", commit_valid, 2'b00);
        wb(3, 3'd0, 64'h100, 1'b0);
        step();
        idle();
        check("cv_both", commit_valid, 2'b11);
        check("c0_result", commit_entry[0].result, 64'h100);
        check("c1_result", commit_entry[1].result, 64'h11);
        check("c1_pc", commit_entry[1].entry.pc, 64'h1004);
        commit_ack = 2'b11;
        step();
        idle();
        check("ack_occ", occupancy, 6);
        check("ack_cv", commit_valid, 2'b00);
        check("ack_ready", issue_ready, 1);

        // tid3 done but tid6 is the youngest x5 producer; tid4 carries an exception
        wb(0, 3'd3, 64'h333, 1'b0);
        wb(2, 3'd4, 64'h444, 1'b1);
        step();
        idle();
        rd_addr[0] = 5'd5;
        rd_fpr[0]  = 1'b0;
        rd_addr[1] = 5'd14;
        rd_fpr[1]  = 1'b0;
        rd_addr[2] = 5'd0;
        rd_fpr[2]  = 1'b0;
        #1;
        check("lk_hit", rd_hit, 3'b011);
        check("lk_valid", rd_valid, 3'b000);
        check("lk_ex_data", rd_data[1], 0);
        wb(2, 3'd6, 64'hDEAD, 1'b0);
        #1;
        check("fwd_same_valid", rd_valid[0], FWD ? 64'd1 : 64'd0);
        check("fwd_same_data", rd_data[0], FWD ? 64'hDEAD : 64'h0);
        step();
        idle();
        check("lk_next_valid", rd_valid[0], 1);
        check("lk_next_data", rd_data[0], 64'hDEAD);
        check("cv_head2_pending", commit_valid, 2'b00);

        // Refill past the wrap point
        issue_valid = 1'b1;
        issue_entry = mk(5'd20, 1'b0, 64'h2000);
        check("wrap_tid0", issue_tid, 0);
        step();
        issue_entry = mk(5'd21, 1'b0, 64'h2004);
        check("wrap_tid1", issue_tid, 1);
        step();
        issue_valid = 1'b0;
        check("refill_occ", occupancy, 8);
        check("refill_ready", issue_ready, 0);

        // Commit while full with issue offered: slot reusable only next cycle
        wb(0, 3'd2, 64'h222, 1'b0);
        step();
        idle();
        check("cv_23", commit_valid, 2'b11);
        check("c0_r222", commit_entry[0].result, 64'h222);
        commit_ack  = 2'b01;
        issue_valid = 1'b1;
        issue_entry = mk(5'd22, 1'b0, 64'h2008);
        check("full_ack_noaccept", issue_ready, 0);
        step();
        commit_ack = '0;
        check("after_ack_occ", occupancy, 7);
        check("after_ack_ready", issue_ready, 1);
        check("after_ack_tid", issue_tid, 2);
        step();
        issue_valid = 1'b0;
        check("reuse_occ", occupancy, 8);
        check("cv_34", commit_valid, 2'b11);
        check("c1_exv", commit_entry[1].ex.valid, 1);
        check("c1_cause", commit_entry[1].ex.cause, 5);

        // Flush beats concurrent writeback and commit
        flush = 1'b1;
        wb(0, 3'd5, 64'h555, 1'b0);
        commit_ack = 2'b11;
        step();
        idle();
        check("fl_occ", occupancy, 0);
        check("fl_gbusy", gpr_busy, 0);
        check("fl_fbusy", fpr_busy, 0);
        check("fl_cv", commit_valid, 0);
        check("fl_tid", issue_tid, 0);
        check("fl_ready", issue_ready, 1);
        check("fl_hit", rd_hit, 0);
        wb(1, 3'd2, 64'h999, 1'b0);
        step();
        idle();
        check("late_wb_cv", commit_valid, 0);
        check("late_wb_occ", occupancy, 0);

        // Reset in the middle of live traffic
        for (int i = 0; i < 5; i++) begin
            issue_valid = 1'b1;
            issue_entry = mk(5'(i + 1), 1'b0, 64'h3000 + 64'(4 * i));
            step();
        end
        issue_valid = 1'b0;
        wb(0, 3'd0, 64'h77, 1'b0);
        step();
        idle();
        check("pre_rst_occ", occupancy, 5);
        check("pre_rst_cv", commit_valid, 2'b01);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_ready", issue_ready, 1);
        check("mid_rst_cv", commit_valid, 0);
        check("mid_rst_tid", issue_tid, 0);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_gbusy", gpr_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
